fast_score_nms: RTL and testbench

//  3x3 non-maximum suppression stage directly downstream of the FAST score calculator.
//  - Input: raster stream of per-pixel corner scores.
//  - Keeps a pixel only if it passes a score threshold and is the 3x3 local maximum.
//  - Emits one keypoint event (x, y, score) per surviving pixel, plus a per-frame count.
//  - Feeds the keypoint FIFO / orientation stage.

---
 rtl/fast_score_nms_if.sv | 27 ++
 rtl/fast_score_nms.sv | 198 +++++++++++++++++++
 tb/tb_fast_score_nms.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fast_score_nms_if.sv
// Score stream in, keypoint events and per-frame count out.
interface fast_score_nms_if #(
   parameter int SCORE_W = 16,
   parameter int CNT_W   = 16
);
   logic               image_vs;
   logic               image_hs;
   logic               image_en;
   logic [SCORE_W-1:0] image_data;
   logic [SCORE_W-1:0] threshold;
   logic               kp_valid;
   logic [15:0]        kp_x;
   logic [15:0]        kp_y;
   logic [SCORE_W-1:0] kp_score;
   logic               frame_done;
   logic [CNT_W-1:0]   frame_kp_count;

   modport master (
      output image_vs, image_hs, image_en, image_data, threshold,
      input  kp_valid, kp_x, kp_y, kp_score, frame_done, frame_kp_count
   );

   modport slave (
      input  image_vs, image_hs, image_en, image_data, threshold,
      output kp_valid, kp_x, kp_y, kp_score, frame_done, frame_kp_count
   );
endinterface

// File: rtl/fast_score_nms.sv
// 3x3 non-maximum suppression on a raster stream of FAST corner scores.
// A pixel survives when it clears the latched threshold and is the local maximum
// of its 3x3 neighbourhood (strict against earlier raster neighbours, >= against
// later ones, so a plateau keeps only its top-left-most pixel).
module fast_score_nms #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int SCORE_W    = 16,
   parameter int CNT_W      = 16
) (
   input logic            i_clk,
   input logic            i_rst,
   fast_score_nms_if.slave bus
);

   localparam int          XW     = $clog2(IMG_WIDTH);
   localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
   localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

   // Keypoint decision: unsigned compares, earlier neighbours strict, later ones >=.
   function automatic logic is_kp(
      input logic [SCORE_W-1:0] c,
      input logic [SCORE_W-1:0] tl, t, tr, l, r, bl, b, br,
      input logic [SCORE_W-1:0] thr
   );
      return (c >= thr) && (c != '0) &&
             (c > tl) && (c > t) && (c > tr) && (c > l) &&
             (c >= r) && (c >= bl) && (c >= b) && (c >= br);
   endfunction

   // Saturating increment for the keypoint counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != '1))
         return v + CNT_W'(1);
      return v;
   endfunction

   // Frame control state
   logic               vs_q;
   logic               low_seen;
   logic               armed;
   logic               full;
   logic [15:0]        x_cnt;
   logic [15:0]        y_cnt;
   logic [SCORE_W-1:0] thr_q;

   logic               rise;
   logic               fall;
   logic               accept;
   logic [15:0]        pos_x;
   logic [15:0]        pos_y;
   logic               full_now;
   logic [XW-1:0]      col;

   // Storage and window (stage p0)
   logic [SCORE_W-1:0] lb1_mem [IMG_WIDTH];
   logic [SCORE_W-1:0] lb2_mem [IMG_WIDTH];
   logic [SCORE_W-1:0] win_p0  [3][3];
   logic               vld_p0;
   logic               cand_p0;
   logic [15:0]        cx_p0;
   logic [15:0]        cy_p0;
   logic               hit_p0;

   // Output stage (p1)
   logic               kp_valid_p1;
   logic [15:0]        kp_x_p1;
   logic [15:0]        kp_y_p1;
   logic [SCORE_W-1:0] kp_score_p1;
   logic               done_p1;
   logic [CNT_W-1:0]   frame_cnt_p1;
   logic [CNT_W-1:0]   run_cnt;

   // Edge detection and current pixel position; a rising edge restarts at (0,0)
   // in the same cycle so a pixel arriving with vs is accepted as the first one.
   // low_seen stops a reset released mid-frame from mistaking vs=1 for a new edge.
   always_comb begin
      rise     = bus.image_vs & ~vs_q & low_seen;
      fall     = ~bus.image_vs & vs_q & armed;
      pos_x    = rise ? 16'd0 : x_cnt;
      pos_y    = rise ? 16'd0 : y_cnt;
      full_now = rise ? 1'b0 : full;
      accept   = bus.image_en & bus.image_vs & (armed | rise) & ~full_now;
      col      = pos_x[XW-1:0];
   end

   // Frame control: arming, raster position, end-of-frame saturation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vs_q     <= 1'b0;
         low_seen <= 1'b0;
         armed    <= 1'b0;
         full     <= 1'b0;
         x_cnt    <= '0;
         y_cnt    <= '0;
      end else begin
         vs_q <= bus.image_vs;
         if (!bus.image_vs)
            low_seen <= 1'b1;
         if (rise)
            armed <= 1'b1;
         else if (fall)
            armed <= 1'b0;
         if (rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
            full  <= 1'b0;
         end
         if (accept) begin
            if (pos_x == X_LAST) begin
               x_cnt <= '0;
               if (pos_y == Y_LAST)
                  full <= 1'b1;
               else
                  y_cnt <= pos_y + 16'd1;
            end else begin
               x_cnt <= pos_x + 16'd1;
            end
         end
      end
   end

   // Threshold is frozen for the whole frame at its rising edge.
   always_ff @(posedge i_clk) begin
      if (rise)
         thr_q <= bus.threshold;
   end

   // ---- stage p0: line buffers (read-before-write) and 3x3 window shift ----
   always_ff @(posedge i_clk) begin
      if (accept) begin
         lb1_mem[col] <= bus.image_data;
         lb2_mem[col] <= lb1_mem[col];
         for (int r = 0; r < 3; r++) begin
            win_p0[r][0] <= win_p0[r][1];
            win_p0[r][1] <= win_p0[r][2];
         end
         win_p0[0][2] <= lb2_mem[col];
         win_p0[1][2] <= lb1_mem[col];
         win_p0[2][2] <= bus.image_data;
         cand_p0      <= (pos_x >= 16'd2) && (pos_y >= 16'd2);
         cx_p0        <= pos_x - 16'd1;
         cy_p0        <= pos_y - 16'd1;
      end
   end

   // Valid strobe for the window contents.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         vld_p0 <= 1'b0;
      else
         vld_p0 <= accept;
   end

   // Decision on the window centre.
   always_comb begin
      hit_p0 = vld_p0 & cand_p0 &
               is_kp(win_p0[1][1],
                     win_p0[0][0], win_p0[0][1], win_p0[0][2], win_p0[1][0],
                     win_p0[1][2], win_p0[2][0], win_p0[2][1], win_p0[2][2],
                     thr_q);
   end

   // ---- stage p1: keypoint event, running count and frame summary ----
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         kp_valid_p1  <= 1'b0;
         kp_x_p1      <= '0;
         kp_y_p1      <= '0;
         kp_score_p1  <= '0;
         done_p1      <= 1'b0;
         frame_cnt_p1 <= '0;
         run_cnt      <= '0;
      end else begin
         kp_valid_p1 <= hit_p0;
         if (hit_p0) begin
            kp_x_p1     <= cx_p0;
            kp_y_p1     <= cy_p0;
            kp_score_p1 <= win_p0[1][1];
         end
         done_p1 <= fall;
         if (fall)
            frame_cnt_p1 <= sat_inc(run_cnt, hit_p0);
         if (rise)
            run_cnt <= '0;
         else
            run_cnt <= sat_inc(run_cnt, hit_p0);
      end
   end

   assign bus.kp_valid       = kp_valid_p1;
   assign bus.kp_x           = kp_x_p1;
   assign bus.kp_y           = kp_y_p1;
   assign bus.kp_score       = kp_score_p1;
   assign bus.frame_done     = done_p1;
   assign bus.frame_kp_count = frame_cnt_p1;

endmodule

// File: tb/tb_fast_score_nms.sv
// Bench for fast_score_nms on a 10x8 image: directed frames plus random frames,
// checked every cycle against a whole-frame NMS model.
module tb_fast_score_nms;
   localparam int W = 10;
   localparam int H = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fast_score_nms_if #(.SCORE_W(16), .CNT_W(16)) bus ();

   fast_score_nms #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SCORE_W(16), .CNT_W(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct { int due; int x; int y; int s; } kp_t;
   typedef struct { int due; int cnt; } dn_t;

   logic [15:0] img [H][W];
   kp_t kq[$];
   dn_t dq[$];
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int last_x = 0, last_y = 0, last_s = 0, exp_fcnt = 0;
   int obs_n = 0, obs_x = 0, obs_y = 0, obs_s = 0;
   int frame_exp = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference rule straight from the definition: interior pixel, clears threshold,
   // nonzero, beats raster-earlier neighbours strictly and later ones or ties.
   function automatic bit model_kp(input int cx, input int cy, input int thr);
      int c, n;
      if (cx < 1 || cy < 1 || cx > W-2 || cy > H-2) return 0;
      c = int'(img[cy][cx]);
      if (c < thr || c == 0) return 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            n = int'(img[cy+dy][cx+dx]);
            if ((dy < 0) || (dy == 0 && dx < 0)) begin
               if (!(c > n)) return 0;
            end else begin
               if (!(c >= n)) return 0;
            end
         end
      return 1;
   endfunction

   task automatic clear_img();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = 16'd0;
   endtask

   task automatic model_reset();
      kq.delete();
      dq.delete();
      last_x = 0; last_y = 0; last_s = 0; exp_fcnt = 0;
   endtask

   // Per-cycle compare against the model, sampled 1 time unit after the edge.
   always @(posedge clk) begin
      bit ev, dn;
      cyc++;
      #1;
      ev = 0; dn = 0;
      if (kq.size() > 0 && kq[0].due == cyc) begin
         ev = 1; last_x = kq[0].x; last_y = kq[0].y; last_s = kq[0].s;
         void'(kq.pop_front());
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
         dn = 1; exp_fcnt = dq[0].cnt;
         void'(dq.pop_front());
      end
      chk("kp_valid", int'(bus.kp_valid), int'(ev));
      chk("kp_x", int'(bus.kp_x), last_x);
      chk("kp_y", int'(bus.kp_y), last_y);
      chk("kp_score", int'(bus.kp_score), last_s);
      chk("frame_done", int'(bus.frame_done), int'(dn));
      chk("frame_kp_count", int'(bus.frame_kp_count), exp_fcnt);
      if (bus.kp_valid === 1'b1) begin
         obs_n++; obs_x = int'(bus.kp_x); obs_y = int'(bus.kp_y); obs_s = int'(bus.kp_score);
      end
   end

   // One frame: vs high, optional lead cycles, raster pixels with optional gaps,
   // optional reset at the start of a row, then exactly one vs-low cycle.
   // Called and returns at a falling clock edge.
   task automatic run_frame(input int thr, input int lines, input int lead,
                            input int maxgap, input int rst_row);
      bit susp;
      int gaps;
      susp = 0;
      frame_exp = 0;
      obs_n = 0;
      bus.image_vs = 1'b1;
      bus.image_hs = 1'b0;
      bus.threshold = 16'(thr);
      bus.image_en = 1'b0;
      repeat (lead) @(negedge clk);
      for (int y = 0; y < lines; y++)
         for (int x = 0; x < W; x++) begin
            gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gaps) begin
               bus.image_en = 1'b0;
               @(negedge clk);
            end
            if (y == rst_row && x == 0) begin
               rst = 1'b1;
               bus.image_en = 1'b0;
               model_reset();
               susp = 1;
               @(negedge clk);
               rst = 1'b0;
            end
            bus.image_en = 1'b1;
            bus.image_hs = 1'b1;
            bus.image_data = img[y][x];
            if (!susp && x >= 2 && y >= 2 && model_kp(x-1, y-1, thr)) begin
               kq.push_back('{due: cyc + 2, x: x-1, y: y-1, s: int'(img[y-1][x-1])});
               frame_exp++;
            end
            @(negedge clk);
            bus.threshold = 16'($urandom);
         end
      bus.image_en = 1'b0;
      bus.image_hs = 1'b0;
      bus.image_vs = 1'b0;
      if (!susp)
         dq.push_back('{due: cyc + 1, cnt: frame_exp});
      @(negedge clk);
   endtask

   initial begin
      bus.image_vs = 1'b0;
      bus.image_hs = 1'b0;
      bus.image_en = 1'b0;
      bus.image_data = 16'd0;
      bus.threshold = 16'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Pin the model with hand-derived answers.
      clear_img(); img[4][4] = 16'd500;
      chk("model_peak", int'(model_kp(4, 4, 100)), 1);
      chk("model_peak_nbr", int'(model_kp(3, 4, 100)), 0);
      clear_img();
      img[3][3] = 16'd300; img[3][4] = 16'd300; img[4][3] = 16'd300; img[4][4] = 16'd300;
      chk("model_plateau_tl", int'(model_kp(3, 3, 100)), 1);
      chk("model_plateau_tr", int'(model_kp(4, 3, 100)), 0);
      chk("model_plateau_bl", int'(model_kp(3, 4, 100)), 0);
      chk("model_plateau_br", int'(model_kp(4, 4, 100)), 0);
      clear_img(); img[2][2] = 16'd100;
      chk("model_thr_eq", int'(model_kp(2, 2, 100)), 1);
      chk("model_thr_above", int'(model_kp(2, 2, 101)), 0);

      // Single isolated peak.
      clear_img(); img[4][4] = 16'd500;
      run_frame(100, H, 1, 0, -1);
      chk("t1_n", obs_n, 1);
      chk("t1_x", obs_x, 4);
      chk("t1_y", obs_y, 4);
      chk("t1_s", obs_s, 500);
      chk("t1_cnt", int'(bus.frame_kp_count), 1);

      // 2x2 plateau: only the top-left pixel survives.
      clear_img();
      img[3][3] = 16'd300; img[3][4] = 16'd300; img[4][3] = 16'd300; img[4][4] = 16'd300;
      run_frame(100, H, 1, 0, -1);
      chk("t2_n", obs_n, 1);
      chk("t2_x", obs_x, 3);
      chk("t2_y", obs_y, 3);
      chk("t2_cnt", int'(bus.frame_kp_count), 1);

      // Threshold boundary.
      clear_img(); img[2][2] = 16'd100;
      run_frame(100, H, 0, 0, -1);
      chk("t3a_n", obs_n, 1);
      chk("t3a_cnt", int'(bus.frame_kp_count), 1);
      run_frame(101, H, 0, 0, -1);
      chk("t3b_n", obs_n, 0);
      chk("t3b_cnt", int'(bus.frame_kp_count), 0);

      // Border peaks never qualify.
      clear_img();
      img[3][0] = 16'd900; img[3][W-1] = 16'd900; img[0][3] = 16'd900; img[H-1][3] = 16'd900;
      run_frame(100, H, 1, 0, -1);
      chk("t4_n", obs_n, 0);
      chk("t4_cnt", int'(bus.frame_kp_count), 0);

      // Reset in row 4 after one keypoint, then a normal frame.
      clear_img(); img[2][2] = 16'd400; img[5][5] = 16'd700;
      run_frame(100, H, 1, 0, 4);
      chk("t5_n", obs_n, 1);
      chk("t5_cnt", int'(bus.frame_kp_count), 0);
      clear_img(); img[4][4] = 16'd500;
      run_frame(100, H, 1, 0, -1);
      chk("t5b_n", obs_n, 1);
      chk("t5b_cnt", int'(bus.frame_kp_count), 1);

      // Keypoint decided by the very last pixel, vs drops immediately, next frame
      // starts with vs and the first pixel together.
      clear_img(); img[H-2][W-2] = 16'd800;
      run_frame(50, H, 0, 0, -1);
      chk("drain_n", obs_n, 1);
      chk("drain_cnt", int'(bus.frame_kp_count), 1);

      // Random frames, with and without gaps, plus a short frame.
      for (int f = 0; f < 8; f++) begin
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               img[y][x] = 16'($urandom_range(0, 4) * 100 + ((f % 2) ? $urandom_range(0, 3) : 0));
         run_frame((f % 3) * 100, (f == 5) ? 5 : H, f % 3, (f >= 4) ? 3 : 0, -1);
         chk("rnd_n", obs_n, frame_exp);
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
